// File: rtl/data_mem_controller.sv
// MEM-stage data-memory controller: turns pipeline load/store requests
// (byte, half, word, LL/SC) into a req/ack bus transaction with big-endian
// lane steering and load extension, and freezes the result for the pipeline.
module data_mem_controller #(
  parameter int ADDR_W = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemByte,
  input  logic              MemHalf,
  input  logic              MemSignExtend,
  input  logic              LLSC,
  input  logic              LLClear,
  input  logic              IF_Stall,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              M_Stall_Controller,
  output logic              EXC_AdEL,
  output logic              EXC_AdES,
  output logic [ADDR_W-1:0] DataMem_Address,
  output logic [31:0]       DataMem_Out,
  output logic              DataMem_Read,
  output logic [3:0]        DataMem_Write,
  input  logic [31:0]       DataMem_In,
  input  logic              DataMem_Ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t r_state, w_state_next;

  // Control state
  logic        r_llbit;
  logic [31:0] r_result;

  // Request snapshot taken while idle, replayed on the bus while waiting
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_mask;
  logic              r_rd;
  logic              r_byte;
  logic              r_half;
  logic [1:0]        r_off;
  logic              r_sext;
  logic              r_ll;
  logic              r_sc;

  // Byte-lane write enables, bit 3 = most significant byte (big-endian)
  function automatic logic [3:0] lane_mask(input logic byt, input logic half,
                                           input logic [1:0] off);
    if (byt)       lane_mask = 4'b1000 >> off;
    else if (half) lane_mask = off[1] ? 4'b0011 : 4'b1100;
    else           lane_mask = 4'b1111;
  endfunction

  // Replicate the store operand across every lane it could land in
  function automatic logic [31:0] steer_store(input logic byt, input logic half,
                                              input logic [31:0] d);
    if (byt)       steer_store = {4{d[7:0]}};
    else if (half) steer_store = {2{d[15:0]}};
    else           steer_store = d;
  endfunction

  // Select the addressed lane of a read word and zero/sign extend it
  function automatic logic [31:0] load_extract(input logic [31:0] din,
                                               input logic byt, input logic half,
                                               input logic [1:0] off, input logic sext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = din[31:24];
      2'd1:    b = din[23:16];
      2'd2:    b = din[15:8];
      default: b = din[7:0];
    endcase
    h = off[1] ? din[15:0] : din[31:16];
    if (byt)       load_extract = sext ? {{24{b[7]}}, b} : {24'b0, b};
    else if (half) load_extract = sext ? {{16{h[15]}}, h} : {16'b0, h};
    else           load_extract = din;
  endfunction

  logic              w_is_half;
  logic              w_is_word;
  logic              w_sc;
  logic              w_ll;
  logic              w_misalign;
  logic              w_sc_fail;
  logic              w_req;
  logic [3:0]        w_mask_in;
  logic [31:0]       w_wdata_in;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_take;
  logic              w_cur_rd;
  logic              w_cur_byte;
  logic              w_cur_half;
  logic [1:0]        w_cur_off;
  logic              w_cur_sext;
  logic              w_cur_ll;
  logic              w_cur_sc;
  logic [31:0]       w_result;

  assign w_is_half   = ~MemByte & MemHalf;
  assign w_is_word   = ~MemByte & ~MemHalf;
  assign w_sc        = MemWrite & LLSC;
  assign w_ll        = MemRead & LLSC;
  assign w_misalign  = (w_is_word & (Address[1:0] != 2'b00)) | (w_is_half & Address[0]);
  assign w_sc_fail   = w_sc & ~r_llbit;
  assign w_req       = (MemRead | MemWrite) & ~w_misalign & ~w_sc_fail & ~reset;
  assign w_mask_in   = MemWrite ? (w_sc ? 4'b1111 : lane_mask(MemByte, w_is_half, Address[1:0]))
                                : 4'b0000;
  assign w_wdata_in  = w_sc ? WriteData : steer_store(MemByte, w_is_half, WriteData);
  assign w_word_addr = Address[ADDR_W+1:2];

  assign EXC_AdEL = ~reset & MemRead & w_misalign;
  assign EXC_AdES = ~reset & MemWrite & w_misalign;

  // While idle the live request describes the access; afterwards the snapshot does
  assign w_cur_rd   = (r_state == S_IDLE) ? MemRead       : r_rd;
  assign w_cur_byte = (r_state == S_IDLE) ? MemByte       : r_byte;
  assign w_cur_half = (r_state == S_IDLE) ? w_is_half     : r_half;
  assign w_cur_off  = (r_state == S_IDLE) ? Address[1:0]  : r_off;
  assign w_cur_sext = (r_state == S_IDLE) ? MemSignExtend : r_sext;
  assign w_cur_ll   = (r_state == S_IDLE) ? w_ll          : r_ll;
  assign w_cur_sc   = (r_state == S_IDLE) ? w_sc          : r_sc;

  assign w_take   = DataMem_Ack & (((r_state == S_IDLE) & w_req) | (r_state == S_WAIT));
  assign w_result = w_cur_rd ? load_extract(DataMem_In, w_cur_byte, w_cur_half,
                                            w_cur_off, w_cur_sext)
                             : {31'b0, w_cur_sc};

  assign ReadData = (~reset & (r_state == S_DONE)) ? r_result : 32'b0;

  // Next-state and bus strobes: issue from IDLE, replay snapshot in WAIT, quiet in DONE
  always_comb begin
    w_state_next       = r_state;
    DataMem_Read       = 1'b0;
    DataMem_Write      = 4'b0000;
    DataMem_Address    = '0;
    DataMem_Out        = 32'b0;
    M_Stall_Controller = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          DataMem_Read       = MemRead;
          DataMem_Write      = w_mask_in;
          DataMem_Address    = w_word_addr;
          DataMem_Out        = w_wdata_in;
          M_Stall_Controller = 1'b1;
          w_state_next       = DataMem_Ack ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        DataMem_Read       = r_rd;
        DataMem_Write      = r_mask;
        DataMem_Address    = r_addr;
        DataMem_Out        = r_wdata;
        M_Stall_Controller = 1'b1;
        if (DataMem_Ack) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (!IF_Stall) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (reset) begin
      DataMem_Read       = 1'b0;
      DataMem_Write      = 4'b0000;
      M_Stall_Controller = 1'b0;
    end
  end

  // State register, LL reservation bit and completed-result register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_llbit  <= 1'b0;
      r_result <= 32'b0;
    end else begin
      r_state <= w_state_next;
      if (w_take) r_result <= w_result;
      if (LLClear)                 r_llbit <= 1'b0;
      else if (w_take & w_cur_ll)  r_llbit <= 1'b1;
      else if (w_take & w_cur_sc)  r_llbit <= 1'b0;
    end
  end

  // Snapshot of the request taken every idle cycle so WAIT can hold the bus steady
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE) begin
      r_addr  <= w_word_addr;
      r_wdata <= w_wdata_in;
      r_mask  <= w_mask_in;
      r_rd    <= MemRead;
      r_byte  <= MemByte;
      r_half  <= w_is_half;
      r_off   <= Address[1:0];
      r_sext  <= MemSignExtend;
      r_ll    <= w_ll;
      r_sc    <= w_sc;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Testbench for data_mem_controller: directed scenarios plus randomized
// accesses checked against a transaction-level reference model.
module tb_data_mem_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemByte, MemHalf, MemSignExtend, LLSC, LLClear, IF_Stall;
  logic [31:0] Address, WriteData, ReadData;
  logic        M_Stall_Controller, EXC_AdEL, EXC_AdES;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out, DataMem_In;
  logic        DataMem_Read, DataMem_Ack;
  logic [3:0]  DataMem_Write;

  int total = 0;
  int bad   = 0;
  bit model_ll = 1'b0;

  data_mem_controller #(.ADDR_W(30)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemByte(MemByte), .MemHalf(MemHalf), .MemSignExtend(MemSignExtend),
    .LLSC(LLSC), .LLClear(LLClear), .IF_Stall(IF_Stall), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData),
    .M_Stall_Controller(M_Stall_Controller), .EXC_AdEL(EXC_AdEL), .EXC_AdES(EXC_AdES),
    .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
    .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_In(DataMem_In), .DataMem_Ack(DataMem_Ack)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; MemByte = 0; MemHalf = 0; MemSignExtend = 0;
    LLSC = 0; LLClear = 0; IF_Stall = 0; Address = 0; WriteData = 0;
    DataMem_In = 0; DataMem_Ack = 0;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clock);
    check({tag, "_stall"}, M_Stall_Controller, 0);
    check({tag, "_rd"}, DataMem_Read, 0);
    check({tag, "_wr"}, DataMem_Write, 0);
    check({tag, "_rdata"}, ReadData, 0);
  endtask

  task automatic clear_ll();
    LLClear = 1;
    check_quiet("llclr");
    step();
    LLClear = 0;
    model_ll = 0;
  endtask

  // One pipeline memory instruction from issue until the pipeline moves on
  task automatic do_op(input bit rd, input bit wr, input bit byt, input bit half,
                       input bit sext, input bit llsc, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] din,
                       input int d, input int h, input bit clr);
    int          off;
    bit          mis, scfail;
    logic [3:0]  emask;
    logic [31:0] eout, eres, v;
    off    = int'(addr[1:0]);
    mis    = (!byt && !half && off != 0) || (!byt && half && addr[0]);
    scfail = wr && llsc && !model_ll;
    if (byt)       begin emask = 4'(1 << (3 - off)); eout = {4{wdata[7:0]}}; end
    else if (half) begin emask = (off == 0) ? 4'hC : 4'h3; eout = {2{wdata[15:0]}}; end
    else           begin emask = 4'hF; eout = wdata; end
    if (rd) begin
      if (byt) begin
        v = (din >> (8 * (3 - off))) & 32'hFF;
        if (sext && v[7]) v = v | 32'hFFFFFF00;
      end else if (half) begin
        v = (din >> (8 * (2 - off))) & 32'hFFFF;
        if (sext && v[15]) v = v | 32'hFFFF0000;
      end else v = din;
      eres = v;
    end else eres = llsc ? 32'd1 : 32'd0;

    MemRead = rd; MemWrite = wr; MemByte = byt; MemHalf = half;
    MemSignExtend = sext; LLSC = llsc; Address = addr; WriteData = wdata; DataMem_In = din;

    if (mis || scfail) begin
      DataMem_Ack = 0;
      @(negedge clock);
      check("adel", EXC_AdEL, rd && mis);
      check("ades", EXC_AdES, wr && mis);
      check("rej_stall", M_Stall_Controller, 0);
      check("rej_rd", DataMem_Read, 0);
      check("rej_wr", DataMem_Write, 0);
      check("rej_rdata", ReadData, 0);
      step();
      idle_inputs();
      check_quiet("rej_after");
      step();
      return;
    end

    for (int i = 0; i <= d; i++) begin
      DataMem_Ack = (i == d);
      LLClear     = (i == d) && clr;
      @(negedge clock);
      check("acc_stall", M_Stall_Controller, 1);
      check("acc_rd", DataMem_Read, rd);
      check("acc_wr", DataMem_Write, wr ? emask : 4'h0);
      check("acc_addr", DataMem_Address, addr[31:2]);
      if (wr) check("acc_out", DataMem_Out, eout);
      check("acc_exc", {EXC_AdEL, EXC_AdES}, 0);
      step();
    end
    DataMem_Ack = 0;
    LLClear     = 0;
    if (rd && llsc) model_ll = 1;
    if (wr && llsc) model_ll = 0;
    if (clr)        model_ll = 0;

    for (int j = 0; j <= h; j++) begin
      IF_Stall = (j < h);
      @(negedge clock);
      check("done_stall", M_Stall_Controller, 0);
      check("done_rd", DataMem_Read, 0);
      check("done_wr", DataMem_Write, 0);
      check("done_rdata", ReadData, eres);
      step();
    end
    idle_inputs();
    check_quiet("idle");
    step();
  endtask

  initial begin
    int          k;
    logic [31:0] a;
    bit          rd, wr, byt, half, sext, llsc;

    idle_inputs();
    reset = 1;
    step();
    step();
    @(negedge clock);
    check("rst_stall", M_Stall_Controller, 0);
    check("rst_rd", DataMem_Read, 0);
    check("rst_wr", DataMem_Write, 0);
    check("rst_rdata", ReadData, 0);
    check("rst_exc", {EXC_AdEL, EXC_AdES}, 0);
    step();
    reset = 0;
    step();

    // lw with three wait cycles
    do_op(1, 0, 0, 0, 0, 0, 32'h100, 0, 32'hDEADBEEF, 3, 0, 0);
    // byte and half loads with extension
    do_op(1, 0, 1, 0, 1, 0, 32'h103, 0, 32'h123456F0, 1, 0, 0);
    do_op(1, 0, 1, 0, 0, 0, 32'h103, 0, 32'h123456F0, 0, 0, 0);
    do_op(1, 0, 0, 1, 1, 0, 32'h102, 0, 32'h123456F0, 2, 0, 0);
    do_op(1, 0, 0, 1, 1, 0, 32'h100, 0, 32'h8001FFFF, 0, 0, 0);
    // byte and half stores
    do_op(0, 1, 1, 0, 0, 0, 32'h201, 32'h000000AB, 0, 1, 0, 0);
    do_op(0, 1, 0, 1, 0, 0, 32'h202, 32'h0000BEEF, 0, 0, 0, 0);
    // misaligned accesses
    do_op(1, 0, 0, 0, 0, 0, 32'h102, 0, 0, 0, 0, 0);
    do_op(0, 1, 0, 1, 0, 0, 32'h101, 32'h1234, 0, 0, 0, 0);
    // LL then SC succeeds; second SC fails
    do_op(1, 0, 0, 0, 0, 1, 32'h300, 0, 32'h55AA55AA, 1, 0, 0);
    do_op(0, 1, 0, 0, 0, 1, 32'h300, 32'hCAFEF00D, 0, 2, 0, 0);
    do_op(0, 1, 0, 0, 0, 1, 32'h300, 32'hCAFEF00D, 0, 0, 0, 0);
    // LL, LLClear, SC fails
    do_op(1, 0, 0, 0, 0, 1, 32'h300, 0, 32'h1, 0, 0, 0);
    clear_ll();
    do_op(0, 1, 0, 0, 0, 1, 32'h300, 32'h7, 0, 0, 0, 0);
    // LLClear coinciding with LL completion wins
    do_op(1, 0, 0, 0, 0, 1, 32'h304, 0, 32'h2, 1, 0, 1);
    do_op(0, 1, 0, 0, 0, 1, 32'h304, 32'h7, 0, 0, 0, 0);
    // result held through a frozen pipeline
    do_op(1, 0, 0, 0, 0, 0, 32'h400, 0, 32'h0BADF00D, 1, 2, 0);

    // reset during WAIT abandons the access and drops the reservation
    do_op(1, 0, 0, 0, 0, 1, 32'h300, 0, 32'h3, 0, 0, 0);
    MemRead = 1; Address = 32'h500; DataMem_In = 32'h99;
    @(negedge clock);
    check("rw_issue_rd", DataMem_Read, 1);
    step();
    @(negedge clock);
    check("rw_wait_stall", M_Stall_Controller, 1);
    step();
    reset = 1;
    step();
    @(negedge clock);
    check("rw_rst_rd", DataMem_Read, 0);
    check("rw_rst_stall", M_Stall_Controller, 0);
    step();
    reset = 0;
    idle_inputs();
    model_ll = 0;
    check_quiet("rw_idle");
    step();
    do_op(0, 1, 0, 0, 0, 1, 32'h300, 32'h7, 0, 0, 0, 0);
    do_op(1, 0, 0, 0, 0, 0, 32'h600, 0, 32'h13572468, 0, 0, 0);

    // randomized accesses
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      rd = 0; wr = 0; byt = 0; half = 0; sext = 0; llsc = 0;
      case (k)
        0: rd = 1;
        1: begin rd = 1; half = 1; sext = 1; end
        2: begin rd = 1; half = 1; end
        3: begin rd = 1; byt = 1; sext = 1; end
        4: begin rd = 1; byt = 1; end
        5: wr = 1;
        6: begin wr = 1; half = 1; end
        7: begin wr = 1; byt = 1; end
        8: begin rd = 1; llsc = 1; end
        default: begin wr = 1; llsc = 1; end
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (!byt && !half) a[1:0] = 2'b00;
        else if (half)     a[0]   = 1'b0;
      end
      do_op(rd, wr, byt, half, sext, llsc, a, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) clear_ll();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
